// File: rtl/multicycle_main_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_ctrl_pkg
// Description : Shared types and constants for the multi-cycle MIPS main
//               controller: state encoding, opcodes, mux selects, fault codes.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_main_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_ADDI_WB   = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_FAULT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // States that wait on the memory handshake and are covered by the watchdog
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage : multicycle_main_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_main_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_ctrl_if
// Description : Bundle of controller inputs (opcode, flags, memory handshake)
//               and all datapath control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_main_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic [1:0] fault_code;

    // Controller side
    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
               alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, halted, fault_code
    );

    // Datapath / memory side
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
               alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, halted, fault_code
    );
endinterface : multicycle_main_ctrl_if
`default_nettype wire

// File: rtl/multicycle_main_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_ctrl_mem_wait_timer
// Description : Saturating wait-cycle counter for the memory watchdog.
//               expired is high while the current wait cycle is the
//               MEM_TIMEOUT-th consecutive one. MEM_TIMEOUT = 0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic expired
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] count;

    // Count consecutive wait cycles; clear wins, saturate at MEM_TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    // count holds the number of earlier wait cycles, so the current one is
    // the MEM_TIMEOUT-th when count has reached MEM_TIMEOUT-1
    generate
        if (MEM_TIMEOUT > 0) begin : g_watchdog_on
            assign expired = (count >= CNT_LAST);
        end else begin : g_watchdog_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule : multicycle_main_ctrl_mem_wait_timer
`default_nettype wire

// File: rtl/multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_ctrl
// Description : Main control FSM of the multi-cycle MIPS datapath with memory
//               wait states, memory watchdog and sticky FAULT/halt state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_ctrl
    import multicycle_main_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_main_ctrl_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic [1:0] fault_code;
    logic [1:0] next_fault;
    logic       in_mem;
    logic       wait_clear;
    logic       wait_incr;
    logic       wait_expired;
    logic       timeout;
    logic       pc_write;
    logic       pc_write_cond;

    assign in_mem     = is_mem_state(state);
    // Counter is idle outside memory states, so it is already zero on entry
    assign wait_clear = !in_mem || bus.mem_ready;
    assign wait_incr  = in_mem && !bus.mem_ready;
    // A completing access on the timeout cycle takes priority over the fault
    assign timeout    = wait_incr && wait_expired;

    multicycle_main_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .incr    (wait_incr),
        .expired (wait_expired)
    );

    // State register plus sticky fault code captured on first entry to FAULT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fault_code <= FAULT_NONE;
        end else begin
            state <= next_state;
            if ((state != ST_FAULT) && (next_state == ST_FAULT)) begin
                fault_code <= next_fault;
            end
        end
    end

    // Next-state decode from state, opcode and memory handshake
    always_comb begin
        next_state = state;
        next_fault = FAULT_NONE;
        case (state)
            ST_IDLE: next_state = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    next_state = ST_DECODE;
                end else if (timeout) begin
                    next_state = ST_FAULT;
                    next_fault = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      next_state = ST_EXECUTE;
                    OP_LW, OP_SW:  next_state = ST_MEM_ADDR;
                    OP_BEQ:        next_state = ST_BRANCH;
                    OP_J:          next_state = ST_JUMP;
                    OP_ADDI:       next_state = ST_ADDI_EXEC;
                    default: begin
                        next_state = ST_FAULT;
                        next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: next_state = (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ, ST_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    next_state = (state == ST_MEM_READ) ? ST_MEM_WB : ST_FETCH;
                end else if (timeout) begin
                    next_state = ST_FAULT;
                    next_fault = FAULT_TIMEOUT;
                end
            end
            ST_MEM_WB:    next_state = ST_FETCH;
            ST_EXECUTE:   next_state = ST_ALU_WB;
            ST_ALU_WB:    next_state = ST_FETCH;
            ST_ADDI_EXEC: next_state = ST_ADDI_WB;
            ST_ADDI_WB:   next_state = ST_FETCH;
            ST_BRANCH:    next_state = ST_FETCH;
            ST_JUMP:      next_state = ST_FETCH;
            ST_FAULT:     next_state = ST_FAULT;
            default: begin
                next_state = ST_FAULT;
                next_fault = FAULT_ILLEGAL;
            end
        endcase
    end

    // Moore output decode; only ir_write and pc_en look at live inputs
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_source  = PC_SRC_ALU;
        bus.alu_op     = ALU_OP_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ALU_SRC_B_REG;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALU_SRC_B_FOUR;
                bus.ir_write  = bus.mem_ready;
                pc_write      = bus.mem_ready;
            end
            ST_DECODE: begin
                bus.alu_src_b = ALU_SRC_B_IMM_SH2;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALU_SRC_B_IMM;
            end
            ST_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_FUNCT;
            end
            ST_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            ST_ADDI_WB: begin
                bus.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_SUB;
                bus.pc_source = PC_SRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            ST_JUMP: begin
                bus.pc_source = PC_SRC_JUMP;
                pc_write      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_en      = pc_write | (pc_write_cond & bus.zero);
    assign bus.halted     = (state == ST_FAULT);
    assign bus.fault_code = fault_code;

endmodule : multicycle_main_ctrl
`default_nettype wire

// File: tb/tb_multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_ctrl
// Description : Scoreboard bench: directed per-cycle stimulus pushes the
//               hand-written expected control vector; a monitor on the falling
//               edge pops and compares it against the controller outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_main_ctrl_if bus ();

    multicycle_main_ctrl #(
        .MEM_TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Vector layout: mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source[2],
    // alu_op[2], alu_src_a, alu_src_b[2], reg_write, reg_dst, mem_to_reg,
    // halted, fault_code[2]
    function automatic logic [17:0] mk(
        input logic mr, input logic mw, input logic iod, input logic irw,
        input logic pce, input logic [1:0] pcs, input logic [1:0] aop,
        input logic sa, input logic [1:0] sb, input logic rw, input logic rd,
        input logic m2r, input logic h, input logic [1:0] fc);
        return {mr, mw, iod, irw, pce, pcs, aop, sa, sb, rw, rd, m2r, h, fc};
    endfunction

    localparam logic [17:0] V_IDLE      = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_FETCH_RDY = mk(1,0,0,1,1,2'b00,2'b00,0,2'b01,0,0,0,0,2'b00);
    localparam logic [17:0] V_FETCH_WT  = mk(1,0,0,0,0,2'b00,2'b00,0,2'b01,0,0,0,0,2'b00);
    localparam logic [17:0] V_DECODE    = mk(0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0,2'b00);
    localparam logic [17:0] V_MEM_ADDR  = mk(0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0,2'b00);
    localparam logic [17:0] V_MEM_READ  = mk(1,0,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_MEM_WB    = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,1,0,2'b00);
    localparam logic [17:0] V_MEM_WRITE = mk(0,1,1,0,0,2'b00,2'b00,0,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_EXECUTE   = mk(0,0,0,0,0,2'b00,2'b10,1,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_ALU_WB    = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,1,1,0,0,2'b00);
    localparam logic [17:0] V_ADDI_EXEC = mk(0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0,2'b00);
    localparam logic [17:0] V_ADDI_WB   = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,1,0,0,0,2'b00);
    localparam logic [17:0] V_BR_TAKEN  = mk(0,0,0,0,1,2'b01,2'b01,1,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_BR_NOT    = mk(0,0,0,0,0,2'b01,2'b01,1,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_JUMP      = mk(0,0,0,0,1,2'b10,2'b00,0,2'b00,0,0,0,0,2'b00);
    localparam logic [17:0] V_FAULT_IL  = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,1,2'b01);
    localparam logic [17:0] V_FAULT_TO  = mk(0,0,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,1,2'b10);

    logic [17:0] exp_q [$];
    string       name_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    wire [17:0] actual = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                          bus.pc_en, bus.pc_source, bus.alu_op, bus.alu_src_a,
                          bus.alu_src_b, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                          bus.halted, bus.fault_code};

    // Monitor: compare one expected vector per cycle, mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (actual !== e) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b at %0t", n, actual, e, $time);
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge
    task automatic step(input logic r, input logic [5:0] op, input logic z,
                        input logic rdy, input logic [17:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Reset, release, and the single IDLE cycle
    task automatic do_reset(input string nm);
        step(0, 6'b000000, 0, 1, V_IDLE, {nm, "_rst"});
        step(1, 6'b000000, 0, 1, V_IDLE, {nm, "_idle"});
    endtask

    task automatic fetch_decode(input logic [5:0] op, input string nm);
        step(1, op, 0, 1, V_FETCH_RDY, {nm, "_fetch"});
        step(1, op, 0, 1, V_DECODE,    {nm, "_decode"});
    endtask

    initial begin : stim
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        do_reset("por");

        // R-type
        fetch_decode(6'b000000, "r");
        step(1, 6'b000000, 0, 1, V_EXECUTE, "r_exec");
        step(1, 6'b000000, 0, 1, V_ALU_WB,  "r_wb");
        // addi
        fetch_decode(6'b001000, "addi");
        step(1, 6'b001000, 0, 1, V_ADDI_EXEC, "addi_exec");
        step(1, 6'b001000, 0, 1, V_ADDI_WB,   "addi_wb");
        // lw with three wait cycles in MEM_READ
        fetch_decode(6'b100011, "lw");
        step(1, 6'b100011, 0, 1, V_MEM_ADDR, "lw_addr");
        for (int i = 0; i < 3; i++) step(1, 6'b100011, 0, 0, V_MEM_READ, "lw_read_wait");
        step(1, 6'b100011, 0, 1, V_MEM_READ, "lw_read_done");
        step(1, 6'b100011, 0, 1, V_MEM_WB,   "lw_wb");
        // sw
        fetch_decode(6'b101011, "sw");
        step(1, 6'b101011, 0, 1, V_MEM_ADDR,  "sw_addr");
        step(1, 6'b101011, 0, 1, V_MEM_WRITE, "sw_write");
        // beq taken and not taken
        fetch_decode(6'b000100, "beq1");
        step(1, 6'b000100, 1, 1, V_BR_TAKEN, "beq_taken");
        fetch_decode(6'b000100, "beq0");
        step(1, 6'b000100, 0, 1, V_BR_NOT, "beq_not_taken");
        // j
        fetch_decode(6'b000010, "j");
        step(1, 6'b000010, 0, 1, V_JUMP, "j_jump");
        // 14 wait cycles in FETCH, ready on the 15th: no fault
        for (int i = 0; i < 14; i++) step(1, 6'b000010, 0, 0, V_FETCH_WT, "wd_edge_wait");
        step(1, 6'b000010, 0, 1, V_FETCH_RDY, "wd_edge_ready");
        step(1, 6'b000010, 0, 1, V_DECODE,    "wd_edge_decode");
        step(1, 6'b000010, 0, 1, V_JUMP,      "wd_edge_jump");
        // Reset asserted while in MEM_WRITE waiting: mem_write drops at once
        fetch_decode(6'b101011, "swr");
        step(1, 6'b101011, 0, 1, V_MEM_ADDR,  "swr_addr");
        step(1, 6'b101011, 0, 0, V_MEM_WRITE, "swr_write_wait");
        step(0, 6'b101011, 0, 0, V_IDLE,      "swr_async_rst");
        step(1, 6'b101011, 0, 1, V_IDLE,      "swr_idle");
        step(1, 6'b101011, 0, 0, V_FETCH_WT,  "swr_refetch");
        // Watchdog fault: 15 wait cycles in FETCH (one already spent above)
        for (int i = 0; i < 14; i++) step(1, 6'b000000, 0, 0, V_FETCH_WT, "wd_wait");
        for (int i = 0; i < 3; i++)  step(1, 6'b000000, 0, 0, V_FAULT_TO, "wd_fault");
        for (int i = 0; i < 2; i++)  step(1, 6'b000000, 0, 1, V_FAULT_TO, "wd_fault_held");
        do_reset("after_wd");
        // Illegal opcode: FAULT held for 20 cycles whatever the inputs do
        fetch_decode(6'b111111, "ill");
        for (int i = 0; i < 20; i++)
            step(1, (i % 2 == 0) ? 6'b000000 : 6'b111111, i[0], i[1], V_FAULT_IL, "ill_fault");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : guard
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_multicycle_main_ctrl
`default_nettype wire
